bcd_to_led: RTL and testbench



---
 rtl/bcd_to_led.sv | 53 +++++
 tb/tb_bcd_to_led.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_led.sv
// Registered BCD-to-seven-segment decoder with selectable output polarity.
// Define BCD_TO_LED_HEX_EN to show hex glyphs A-F for codes 10-15 instead of blank.
module bcd_to_led (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] number,
    input  logic       LED_TYPE,
    output logic [6:0] LED
);

    // Segment order is {a, b, c, d, e, f, g}; seg_q always holds the active-high pattern.
    logic [6:0] seg_d;
    logic [6:0] seg_q;

    always_comb begin
        // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
        seg_d = 7'b0000000;
        case (number)
            4'd0:  seg_d = 7'b1111110;
            4'd1:  seg_d = 7'b0110000;
            4'd2:  seg_d = 7'b1101101;
            4'd3:  seg_d = 7'b1111001;
            4'd4:  seg_d = 7'b0110011;
            4'd5:  seg_d = 7'b1011011;
            4'd6:  seg_d = 7'b1011111;
            4'd7:  seg_d = 7'b1110000;
            4'd8:  seg_d = 7'b1111111;
            4'd9:  seg_d = 7'b1111011;
`ifdef BCD_TO_LED_HEX_EN
            4'd10: seg_d = 7'b1110111;
            4'd11: seg_d = 7'b0011111;
            4'd12: seg_d = 7'b1001110;
            4'd13: seg_d = 7'b0111101;
            4'd14: seg_d = 7'b1001111;
            4'd15: seg_d = 7'b1000111;
`endif
            default: seg_d = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            seg_q <= 7'b0000000;
        end else begin
            seg_q <= seg_d;
        end
    end

    // Polarity sits after the register so toggling LED_TYPE takes effect immediately.
    assign LED = LED_TYPE ? seg_q : ~seg_q;

endmodule

// File: tb/tb_bcd_to_led.sv
// Directed self-checking bench for bcd_to_led: reset, both polarities, non-BCD codes,
// live polarity toggle and mid-stream asynchronous reset.
module tb_bcd_to_led;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] number;
    logic       LED_TYPE;
    logic [6:0] LED;

    int errors;
    int checks;

    bcd_to_led dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .LED      (LED),
        .number   (number),
        .LED_TYPE (LED_TYPE)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Hand-computed true (active-high) patterns, abcdefg.
    function automatic logic [6:0] true_pattern(input int n);
        case (n)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
`ifdef BCD_TO_LED_HEX_EN
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [6:0] expected);
        checks++;
        assert (LED === expected)
        else begin
            errors++;
            $error("FAIL %s: LED observed=%b expected=%b", tag, LED, expected);
        end
    endtask

    // Present a digit away from the rising edge, then sample just after it.
    task automatic apply(input int n);
        @(negedge clk);
        number = 4'(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        number   = 4'd8;
        LED_TYPE = 1'b1;

        // Reset with no clock running.
        #2;
        check("reset_type1", 7'b0000000);
        LED_TYPE = 1'b0;
        #1;
        check("reset_type0", 7'b1111111);

        // Release reset while the clock is low, then start the clock.
        #2;
        rst_n    = 1'b1;
        LED_TYPE = 1'b1;
        clk_en   = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(i);
            check($sformatf("sweep_t1_%0d", i), true_pattern(i));
        end

        LED_TYPE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(i);
            check($sformatf("sweep_t0_%0d", i), ~true_pattern(i));
        end

        // Polarity toggle between edges with number held at 3.
        LED_TYPE = 1'b1;
        apply(3);
        check("hold3_t1", 7'b1111001);
        LED_TYPE = 1'b0;
        #1;
        check("hold3_t0", 7'b0000110);
        LED_TYPE = 1'b1;
        #1;
        check("hold3_back_t1", 7'b1111001);

        // Non-BCD codes.
        for (int i = 10; i < 16; i++) begin
            apply(i);
`ifdef BCD_TO_LED_HEX_EN
            check($sformatf("hex_%0d", i), true_pattern(i));
`else
            check($sformatf("blank_%0d", i), 7'b0000000);
`endif
        end

        // Mid-cycle reset pulse while showing 8.
        apply(8);
        check("pre_reset_8", 7'b1111111);
        rst_n = 1'b0;
        #1;
        check("mid_reset_dark", 7'b0000000);
        @(posedge clk);
        #1;
        check("reset_holds_over_edge", 7'b0000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_8", 7'b1111111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
